// File: rtl/ts_mixer_if.sv
// ts_mixer bus interface: strobe, mix controls and packed per-chip channel
// amplitudes towards the mixer; saturated stereo sample, valid and busy back.
//   master : drives ce/mode/beeper/mute/chA/chB/chC, observes left/right/valid/busy
//   slave  : the mixer side of the same signals
interface ts_mixer_if #(
    parameter int unsigned PSGS = 2,
    parameter int unsigned CW   = 12,
    parameter int unsigned OW   = 15
);
    logic                 ce;
    logic [1:0]           mode;
    logic [1:0]           beeper;
    logic [PSGS-1:0]      mute;
    logic [PSGS*CW-1:0]   chA;
    logic [PSGS*CW-1:0]   chB;
    logic [PSGS*CW-1:0]   chC;
    logic [OW-1:0]        left;
    logic [OW-1:0]        right;
    logic                 valid;
    logic                 busy;

    modport master (
        output ce, mode, beeper, mute, chA, chB, chC,
        input  left, right, valid, busy
    );

    modport slave (
        input  ce, mode, beeper, mute, chA, chB, chC,
        output left, right, valid, busy
    );
endinterface

// File: rtl/ts_mixer.sv
// ts_mixer: time-multiplexed stereo mixer for the beeper and PSGS AY chips.
// A ce strobe while idle snapshots all inputs, then one chip is accumulated
// per clock, the beeper level is added, and the saturated result is
// published with a one-cycle valid pulse.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : ce, mode, beeper, mute, chA/chB/chC in; left, right, valid, busy out
module ts_mixer #(
    parameter int unsigned PSGS = 2,
    parameter int unsigned CW   = 12,
    parameter int unsigned OW   = 15
) (
    input  logic        clock,
    input  logic        reset,
    ts_mixer_if.slave   bus
);
    localparam int unsigned AW = CW + 5;
    localparam int unsigned KW = (PSGS > 1) ? $clog2(PSGS) : 1;
    localparam int unsigned SW = (AW > OW) ? AW : OW;
    localparam logic [OW-1:0] OMAX = '1;

    typedef enum logic [1:0] {IDLE, ACC, BEEP, OUT} state_t;

    state_t               state;
    logic [1:0]           s_mode;
    logic [1:0]           s_beeper;
    logic [PSGS-1:0]      s_mute;
    logic [PSGS*CW-1:0]   s_a;
    logic [PSGS*CW-1:0]   s_b;
    logic [PSGS*CW-1:0]   s_c;
    logic [KW-1:0]        k;
    logic [AW-1:0]        acc_l;
    logic [AW-1:0]        acc_r;
    logic [OW-1:0]        left_q;
    logic [OW-1:0]        right_q;
    logic                 valid_q;
    logic                 busy_q;

    logic [CW-1:0]        a_k_c;
    logic [CW-1:0]        b_k_c;
    logic [CW-1:0]        c_k_c;
    logic [AW-1:0]        add_l_c;
    logic [AW-1:0]        add_r_c;
    logic [AW-1:0]        beep_lvl_c;

    function automatic logic [OW-1:0] sat(input logic [AW-1:0] v);
        if (SW'(v) > SW'(OMAX)) return OMAX;
        return OW'(v);
    endfunction

    // Per-chip contribution for the current k, routed by the snapshotted mode
    always_comb begin
        a_k_c   = s_a[k*CW +: CW];
        b_k_c   = s_b[k*CW +: CW];
        c_k_c   = s_c[k*CW +: CW];
        add_l_c = '0;
        add_r_c = '0;
        case (s_mode)
            2'd1: begin
                add_l_c = (AW'(a_k_c) << 1) + AW'(c_k_c);
                add_r_c = (AW'(b_k_c) << 1) + AW'(c_k_c);
            end
            2'd2: begin
                add_l_c = AW'(a_k_c) + AW'(b_k_c) + AW'(c_k_c);
                add_r_c = add_l_c;
            end
            default: begin
                add_l_c = (AW'(a_k_c) << 1) + AW'(b_k_c);
                add_r_c = (AW'(c_k_c) << 1) + AW'(b_k_c);
            end
        endcase
    end

    // Beeper level table, scaled to the channel width
    always_comb begin
        beep_lvl_c = '0;
        case (s_beeper)
            2'd1:    beep_lvl_c = AW'(12'd775)  << (CW - 12);
            2'd2:    beep_lvl_c = AW'(12'd3874) << (CW - 12);
            2'd3:    beep_lvl_c = AW'(12'd4095) << (CW - 12);
            default: beep_lvl_c = '0;
        endcase
    end

    // Mix sequencer: snapshot, per-chip accumulate, beeper, publish
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            s_mode   <= '0;
            s_beeper <= '0;
            s_mute   <= '0;
            s_a      <= '0;
            s_b      <= '0;
            s_c      <= '0;
            k        <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ce) begin
                        s_mode   <= bus.mode;
                        s_beeper <= bus.beeper;
                        s_mute   <= bus.mute;
                        s_a      <= bus.chA;
                        s_b      <= bus.chB;
                        s_c      <= bus.chC;
                        acc_l    <= '0;
                        acc_r    <= '0;
                        k        <= '0;
                        busy_q   <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (!s_mute[k]) begin
                        acc_l <= acc_l + add_l_c;
                        acc_r <= acc_r + add_r_c;
                    end
                    if (k == KW'(PSGS - 1)) begin
                        state <= BEEP;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                BEEP: begin
                    acc_l <= acc_l + beep_lvl_c;
                    acc_r <= acc_r + beep_lvl_c;
                    state <= OUT;
                end
                OUT: begin
                    left_q  <= sat(acc_l);
                    right_q <= sat(acc_r);
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.left  = left_q;
    assign bus.right = right_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
endmodule
